// File: rtl/keypad_entry_display.sv
// keypad_entry_display
//   Takes the 4-bit key code from a 3x4 keypad scanner (0-9 digits, 10 = '*',
//   11 = '#'). It debounces the held-key indication and accepts one event per
//   physical press. Accepted digits build a 4-digit BCD entry. '*' clears the
//   entry and '#' commits it. The entry in progress is shown on a multiplexed
//   common-anode 7-segment display.
//
// Ports
//   fin            system clock; all state updates on its rising edge
//   rst            synchronous reset, active-high
//   key_valid      high while the scanner reports a pressed key
//   key_code[3:0]  scanner key code; ignored while key_valid=0
//   seg_S[6:0]     segments {a,b,c,d,e,f,g}, active-low
//   dig_sel[3:0]   digit enable, active-low one-hot; bit0 = rightmost digit
//   commit_pulse   one-cycle strobe on an accepted '#' with a non-empty entry
//   commit_value   last committed BCD value; digit3 in [15:12] ... digit0 in [3:0]
//   entry_count    number of digits currently in the entry (0..4)
//   debounce_state debug view of the debounce FSM (0 IDLE, 1 PRESS_WAIT,
//                  2 HELD, 3 RELEASE_WAIT)
//
// Output contract: there is no valid/ready handshake. commit_pulse is a
// fire-and-forget strobe. The consumer must take commit_value in the same
// cycle or later, because it stays stable until the next commit or reset.
module keypad_entry_display #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int MUX_DIV_W    = 16
) (
  input  logic        fin,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [6:0]  seg_S,
  output logic [3:0]  dig_sel,
  output logic        commit_pulse,
  output logic [15:0] commit_value,
  output logic [2:0]  entry_count,
  output logic [1:0]  debounce_state
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE_CYC);

  state_t               state_q, state_d;
  logic [4:0]           samp_q;
  logic [4:0]           samp_now;
  logic [7:0]           stab_q, stab_d;
  logic                 stable_done;
  logic                 accept;

  logic [15:0]          buf_q, buf_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [15:0]          cval_d;
  logic                 pulse_d;

  logic [MUX_DIV_W-1:0] ref_q, ref_d;
  logic [1:0]           dig_idx;
  logic [3:0]           dig_d;
  logic [3:0]           nib;
  logic [6:0]           seg_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // The code is masked while no key is reported. This means that scanner
  // noise on key_code during a release does not restart the stability count.
  assign samp_now = {key_valid, key_valid ? key_code : 4'd0};

  // The stability count includes the sample taken on this edge. When a press
  // has been held since before edge 1, the count reaches DEBOUNCE_CYC on edge
  // DEBOUNCE_CYC. The count saturates so that a long hold cannot wrap it.
  always_comb begin
    stab_d = stab_q;
    if (samp_now != samp_q) begin
      stab_d = 8'd1;
    end else if (stab_q != 8'hFF) begin
      stab_d = stab_q + 8'd1;
    end
  end

  assign stable_done = (stab_d >= DEB_LIM);

  // Debounce FSM: the next state is decided from the sample taken on this edge.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_valid) state_d = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (!key_valid) begin
          state_d = ST_IDLE;
        end else if (stable_done) begin
          accept  = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!key_valid) state_d = ST_RELEASE_WAIT;
      end
      ST_RELEASE_WAIT: begin
        if (key_valid) begin
          state_d = ST_HELD;
        end else if (stable_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Entry buffer. The newest digit enters at nibble 0, which is the rightmost
  // display position.
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    cval_d  = commit_value;
    pulse_d = 1'b0;
    if (accept) begin
      if (key_code <= 4'd9) begin
        if (cnt_q < 3'd4) begin
          buf_d = {buf_q[11:0], key_code};
          cnt_d = cnt_q + 3'd1;
        end
      end else if (key_code == 4'd10) begin
        buf_d = 16'h0000;
        cnt_d = 3'd0;
      end else if (key_code == 4'd11 && cnt_q != 3'd0) begin
        cval_d  = buf_q;
        pulse_d = 1'b1;
        buf_d   = 16'h0000;
        cnt_d   = 3'd0;
      end
    end
  end

  // Display. The segment and digit registers are loaded from the post-edge
  // counter and buffer values. As a result, the display always matches the
  // state that is visible in the same cycle, and seg_S and dig_sel change
  // together.
  assign ref_d   = ref_q + 1'b1;
  assign dig_idx = ref_d[MUX_DIV_W-1 -: 2];
  assign dig_d   = ~(4'b0001 << dig_idx);
  assign nib     = buf_d[{dig_idx, 2'b00} +: 4];
  assign seg_d   = ({1'b0, dig_idx} < cnt_d) ? seg_decode(nib) : 7'b1111111;

  always_ff @(posedge fin) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      samp_q       <= 5'd0;
      stab_q       <= 8'd0;
      buf_q        <= 16'h0000;
      cnt_q        <= 3'd0;
      commit_value <= 16'h0000;
      commit_pulse <= 1'b0;
      ref_q        <= '0;
      seg_S        <= 7'b1111111;
      dig_sel      <= 4'b1110;
    end else begin
      state_q      <= state_d;
      samp_q       <= samp_now;
      stab_q       <= stab_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      commit_value <= cval_d;
      commit_pulse <= pulse_d;
      ref_q        <= ref_d;
      seg_S        <= seg_d;
      dig_sel      <= dig_d;
    end
  end

  assign entry_count    = cnt_q;
  assign debounce_state = state_q;

endmodule
